// File: rtl/distance_averager.sv
// Moving-average smoother feeding the FM DAC distance input.
// Clamps raw samples to the LUT range, averages the last DEPTH samples with
// a circular buffer plus running sum, and only publishes once a full window
// of real samples has been collected since reset or flush.
module distance_averager #(
    parameter int WIDTH      = 13,
    parameter int LOG2_DEPTH = 4,
    parameter int MAX_DIST   = 2000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_distance,
    output logic [WIDTH-1:0] distance,
    output logic             out_valid
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SUM_W = WIDTH + LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] CNT_FULL = (LOG2_DEPTH + 1)'(DEPTH);

    typedef enum logic {
        FILL,
        RUN
    } state_t;

    state_t                state;
    state_t                state_next;

    logic [WIDTH-1:0]      win_buf [DEPTH];
    logic [LOG2_DEPTH-1:0] wptr_p0;
    logic [SUM_W-1:0]      sum_p0;
    logic [LOG2_DEPTH:0]   cnt_p0;
    logic                  vld_p0;

    logic                  accept;
    logic [WIDTH-1:0]      clamped;
    logic [SUM_W-1:0]      sum_next;
    logic [LOG2_DEPTH:0]   cnt_next;
    logic                  upd_next;

    // Saturate a raw sample to the top address of the frequency-step LUT.
    function automatic logic [WIDTH-1:0] clamp_dist(input logic [WIDTH-1:0] d);
        if (d > WIDTH'(MAX_DIST)) begin
            return WIDTH'(MAX_DIST);
        end
        return d;
    endfunction

    // Clamp, and form the next running sum and saturating fill count.
    always_comb begin
        clamped  = clamp_dist(in_distance);
        accept   = in_valid && !flush;
        // The evicted entry is always part of sum_p0, so the modular result is exact.
        sum_next = sum_p0 + SUM_W'(clamped) - SUM_W'(win_buf[wptr_p0]);
        cnt_next = (cnt_p0 == CNT_FULL) ? CNT_FULL : cnt_p0 + 1'b1;
    end

    // Fill/run next-state logic; an accept that completes the window schedules an output.
    always_comb begin
        state_next = state;
        upd_next   = 1'b0;
        if (flush) begin
            state_next = FILL;
        end else if (accept && (cnt_next == CNT_FULL)) begin
            state_next = RUN;
            upd_next   = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Stage p0: window storage, write pointer, running sum and fill count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                win_buf[i] <= '0;
            end
            wptr_p0 <= '0;
            sum_p0  <= '0;
            cnt_p0  <= '0;
            vld_p0  <= 1'b0;
        end else begin
            vld_p0 <= upd_next;
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    win_buf[i] <= '0;
                end
                wptr_p0 <= '0;
                sum_p0  <= '0;
                cnt_p0  <= '0;
            end else if (accept) begin
                win_buf[wptr_p0] <= clamped;
                wptr_p0          <= wptr_p0 + 1'b1;
                sum_p0           <= sum_next;
                cnt_p0           <= cnt_next;
            end
        end
    end

    // Stage p1: publish the truncated average one cycle after the accept; a flush cancels it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            distance  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= vld_p0 && (state == RUN) && !flush;
            if (vld_p0 && (state == RUN) && !flush) begin
                distance <= sum_p0[SUM_W-1:LOG2_DEPTH];
            end
        end
    end

endmodule

// File: tb/tb_distance_averager.sv
// Self-checking bench for distance_averager: directed scenarios plus random
// traffic, compared every cycle against a queue-based moving-average model.
module tb_distance_averager;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic [12:0] in_distance;
    logic [12:0] distance;
    logic        out_valid;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int q[$];
    bit pend;
    int pend_val;
    int exp_dist;
    bit exp_ov;

    distance_averager #(
        .WIDTH(13),
        .LOG2_DEPTH(4),
        .MAX_DIST(2000)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .flush(flush),
        .in_valid(in_valid),
        .in_distance(in_distance),
        .distance(distance),
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        pend     = 1'b0;
        pend_val = 0;
        exp_dist = 0;
        exp_ov   = 1'b0;
    endtask

    // Behavioural effect of one clock edge with the given inputs.
    task automatic model_edge(input bit v, input int d, input bit f);
        int s;
        exp_ov = pend && !f;
        if (exp_ov) exp_dist = pend_val;
        pend = 1'b0;
        if (f) begin
            q.delete();
        end else if (v) begin
            q.push_back((d > 2000) ? 2000 : d);
            if (q.size() > 16) void'(q.pop_front());
            if (q.size() == 16) begin
                s = 0;
                foreach (q[i]) s += q[i];
                pend     = 1'b1;
                pend_val = s / 16;
            end
        end
    endtask

    // One cycle: drive, clock, then compare both outputs against the model.
    task automatic step(input bit v, input int d, input bit f);
        in_valid    = v;
        in_distance = 13'(d);
        flush       = f;
        @(posedge clk);
        #1;
        model_edge(v, d, f);
        check_eq("out_valid", int'(out_valid), int'(exp_ov));
        check_eq("distance", int'(distance), exp_dist);
    endtask

    task automatic burst(input int n, input int d, input int gap);
        for (int i = 0; i < n; i++) begin
            step(1'b1, d, 1'b0);
            for (int g = 0; g < gap; g++) step(1'b0, 0, 1'b0);
        end
    endtask

    // Reset asserted between clock edges; outputs must clear without an edge.
    task automatic async_reset();
        in_valid = 1'b0;
        flush    = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check_eq("async_rst_dist", int'(distance), 0);
        check_eq("async_rst_ov", int'(out_valid), 0);
        model_clear();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        model_edge(1'b0, 0, 1'b0);
        check_eq("post_rst_dist", int'(distance), exp_dist);
    endtask

    initial begin
        reset_n     = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_distance = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_dist", int'(distance), 0);
        check_eq("reset_ov", int'(out_valid), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Partial fill: no pulse, distance stays 0
        burst(15, 1500, 0);
        step(1'b0, 0, 1'b0);
        check_eq("partial_dist", int'(distance), 0);
        check_eq("partial_ov", int'(out_valid), 0);
        step(1'b0, 0, 1'b1);

        // Fill and average
        burst(15, 1000, 0);
        check_eq("fill15_ov", int'(out_valid), 0);
        step(1'b1, 1000, 1'b0);
        check_eq("fill16_ov", int'(out_valid), 0);
        step(1'b0, 0, 1'b0);
        check_eq("fill_pulse", int'(out_valid), 1);
        check_eq("fill_avg", int'(distance), 1000);
        step(1'b0, 0, 1'b0);
        check_eq("fill_single", int'(out_valid), 0);

        // Sliding window with wptr wrap
        step(1'b1, 1016, 1'b0);
        step(1'b0, 0, 1'b0);
        check_eq("slide_one", int'(distance), 1001);
        burst(15, 1016, 0);
        step(1'b0, 0, 1'b0);
        check_eq("slide_full", int'(distance), 1016);

        // Clamp
        burst(16, 5000, 0);
        step(1'b0, 0, 1'b0);
        check_eq("clamp_5000", int'(distance), 2000);
        step(1'b1, 8191, 1'b0);
        step(1'b0, 0, 1'b0);
        check_eq("clamp_8191", int'(distance), 2000);
        check_eq("clamp_8191_ov", int'(out_valid), 1);

        // Flush wins over a simultaneous sample
        step(1'b1, 0, 1'b1);
        check_eq("flush_ov", int'(out_valid), 0);
        check_eq("flush_hold", int'(distance), 2000);
        burst(15, 200, 0);
        step(1'b0, 0, 1'b0);
        check_eq("flush_refill_ov", int'(out_valid), 0);
        check_eq("flush_refill_hold", int'(distance), 2000);
        step(1'b1, 200, 1'b0);
        step(1'b0, 0, 1'b0);
        check_eq("flush_new_avg", int'(distance), 200);
        check_eq("flush_new_ov", int'(out_valid), 1);

        // Async reset mid-window, then sparse input
        burst(5, 700, 0);
        async_reset();
        burst(16, 1000, 6);
        check_eq("sparse_avg", int'(distance), 1000);
        step(1'b1, 1016, 1'b0);
        step(1'b0, 0, 1'b0);
        check_eq("sparse_slide", int'(distance), 1001);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            int d;
            bit v, f;
            v = ($urandom_range(0, 9) < 7);
            f = ($urandom_range(0, 99) < 2);
            d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8191))
                                            : int'($urandom_range(0, 2100));
            step(v, d, f);
            if (i == 700) async_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/distance_averager.md
# distance_averager

Moving-average smoother that sits directly upstream of the FM DAC. It accepts raw distance samples with a valid strobe and clamps each to the frequency-step LUT range. It keeps a power-of-two-deep circular buffer with a running sum and presents a stable, averaged `distance` word that feeds the FM DAC's `distance` input. A fill state machine suppresses `out_valid` until the buffer holds a full window of real samples.

## Interface
- `WIDTH`, 13: bit width of input and output distance; matches the FM DAC `distance` port.
- `LOG2_DEPTH`, 4: log2 of window depth; DEPTH = 2**LOG2_DEPTH = 16.
- `MAX_DIST`, 2000: upper clamp; equals the top address of the distance-to-frequency-step LUT.
- `clk`, input, 1: system clock, 50 MHz.
- `reset_n`, input, 1: asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- `flush`, input, 1: synchronous clear of window contents.
- `in_valid`, input, 1: `in_distance` is sampled on this edge.
- `in_distance`, input, WIDTH: raw distance sample.
- `distance`, output, WIDTH: averaged distance, held between updates.
- `out_valid`, output, 1: one-cycle pulse when `distance` has just been updated.

## Operation
- Clamp: `c = (in_distance > MAX_DIST) ? MAX_DIST : in_distance`. Only `c` enters the buffer.
- Storage:
  - DEPTH x WIDTH register array `buf`.
  - write pointer `wptr`, LOG2_DEPTH bits, wraps DEPTH-1 -> 0 naturally.
  - running `sum`, WIDTH+LOG2_DEPTH bits; no overflow is possible.
  - fill counter `cnt`, LOG2_DEPTH+1 bits, saturating at DEPTH.
- Accept, on an edge with `in_valid`=1 and `flush`=0:
  - `sum <= sum + c - buf[wptr]`, using the old contents read combinationally.
  - `buf[wptr] <= c`.
  - `wptr <= wptr+1`.
  - `cnt <= min(cnt+1, DEPTH)`.
- Output stage, on the edge after an accept:
  - `distance <= sum >> LOG2_DEPTH`, truncating, only if the state is RUN.
  - `out_valid` pulses high for that cycle only, under the same RUN condition.
- State machine:
  - FILL: `cnt` < DEPTH. `distance` holds and `out_valid` stays 0.
  - FILL -> RUN: on the accept that makes `cnt` = DEPTH. That sample's average produces the first `out_valid`.
  - RUN: every accept produces exactly one `out_valid` pulse 1 cycle later.
  - RUN -> FILL: only on `flush`.
- Flush:
  - Clears `buf`, `sum`, `wptr`, `cnt` and the state (to FILL), plus any pending output update.
  - `distance` holds its last value. `out_valid` is 0 on the next cycle.
  - If `flush` and `in_valid` are both high on the same edge, flush wins and the sample is dropped.
- Back-to-back: `in_valid` may be high every cycle; there is no backpressure and no sample is ever lost.

## Timing
- Reset values: `distance`=0, `out_valid`=0, `sum`=0, `wptr`=0, `cnt`=0, all `buf` entries 0, state FILL.
- Latency: an `in_valid` sampled at edge k causes `sum` to update at edge k, and `distance`/`out_valid` to update at edge k+1.
- Throughput: 1 sample/cycle.
- `distance` changes only together with an `out_valid` pulse; it is stable otherwise. The FM DAC may sample it on any cycle.
- Reset asserted mid-operation: all state returns to reset values immediately, independent of `clk`. After release, the block restarts in FILL.

## Test plan
- Fill and average: 16 accepts of 1000 at one per cycle.
  - `out_valid` stays low for the first 15.
  - A single pulse appears 1 cycle after the 16th accept, with `distance`=1000.
- Partial fill: 15 accepts of 1500.
  - No `out_valid` at any point.
  - `distance` remains 0.
- Clamp: a full window of 5000 -> `distance`=2000. Then 8191 -> still 2000.
- Sliding window, starting from a full window of 1000:
  - One accept of 1016 -> `distance`=1001, since 16016>>4.
  - 15 more accepts of 1016 -> `distance`=1016.
  - This run of accepts exercises `wptr` wrap.
- Flush in RUN with simultaneous `in_valid`=1 and value 0:
  - The sample is dropped.
  - `distance` holds its previous value and `out_valid` stays low.
  - 16 new accepts of 200 are required before the next pulse, which shows `distance`=200.
- Async reset with gaps:
  - Assert `reset_n`=0 between `clk` edges mid-window. All outputs go to 0 without a clock edge.
  - Sparse `in_valid` (one every 7 cycles) then yields the same averages as the back-to-back case.
